// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: ASCII constants, FSM encodings and line-template helpers for debug_uart_rx
package debug_uart_pkg;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_P     = 8'h70;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_2     = 8'h32;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_PCT   = 8'h25;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HUNT, P_HDR1, P_SDIG, P_MID, P_HDIG, P_TAIL} p_state_t;
  function automatic logic [7:0] exp_char(p_state_t s, logic [2:0] i);
    return s == P_HDR1 ? (i == 3'd0 ? CH_P : i == 3'd1 ? CH_O : i == 3'd2 ? CH_2 : CH_COLON) :
           s == P_MID  ? (i == 3'd0 ? CH_PCT : i == 3'd1 ? CH_COMMA : i == 3'd2 ? CH_H :
                          i == 3'd3 ? CH_R : CH_COLON) :
                         (i == 3'd0 ? CH_SP : i == 3'd1 ? CH_CR : CH_LF);
  endfunction
  function automatic logic [2:0] last_idx(p_state_t s);
    return s == P_HDR1 ? 3'd3 : s == P_MID ? 3'd4 : 3'd2;
  endfunction
  function automatic p_state_t next_field(p_state_t s);
    return s == P_HDR1 ? P_SDIG : s == P_SDIG ? P_MID : s == P_MID ? P_HDIG :
           s == P_HDIG ? P_TAIL : P_HUNT;
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 byte receiver with 2-flop input synchronizer and mid-bit sampling
// ports: clk, rst_n (sync, active-low), rx_pin (async line, idle high),
//        rx_data (last good byte), rx_data_valid (1-cycle byte strobe),
//        rx_frame_err (1-cycle pulse on low stop bit)
module uart_rx
  import debug_uart_pkg::*;
#(
  parameter int CLK_FRE   = 33,
  parameter int BAUD_RATE = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_frame_err
);
  localparam int BIT_CYC = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  rx_state_t st, nst;
  logic rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic fall, half, full;
  assign fall = rx_d & ~rx_s2;
  assign half = cnt == HALF;
  assign full = cnt == LAST;
  // a low stop bit returns to IDLE at once: IDLE only reacts to a falling edge,
  // so the receiver implicitly waits for the line to go high again
  always_comb
    nst = st == RX_IDLE  ? (fall ? RX_START : RX_IDLE) :
          st == RX_START ? (half ? (rx_s2 ? RX_IDLE : RX_DATA) : RX_START) :
          st == RX_DATA  ? (full && bit_idx == 3'd7 ? RX_STOP : RX_DATA) :
                           (full ? RX_IDLE : RX_STOP);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {rx_d, rx_s2, rx_s1} <= 3'b111;
      st <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_data_valid <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      {rx_d, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx_pin};
      st <= nst;
      cnt <= (st == RX_IDLE || nst != st || full) ? '0 : cnt + 1'b1;
      if (st == RX_DATA && full) begin
        shreg <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (st == RX_STOP && full && rx_s2) rx_data <= shreg;
      rx_data_valid <= st == RX_STOP && full && rx_s2;
      rx_frame_err <= st == RX_STOP && full && !rx_s2;
    end
  end
endmodule

// File: rtl/debug_uart_rx.sv
// debug_uart_rx: receives "SpO2:DDD%,HR:DDD \r\n" lines over UART and publishes the values
// ports: clk, rst_n (sync, active-low), uart_rx (async line), spo2_value[7:0], hr_value[9:0],
//        data_valid / frame_err / parse_err (1-cycle pulses)
// option: DEBUG_UART_RX_TIMEOUT_EN aborts a stalled partial line after 16 byte times
module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int CLK_FRE   = 33,
  parameter int BAUD_RATE = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] spo2_value,
  output logic [9:0] hr_value,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parse_err
);
  logic [7:0] rx_data;
  logic rx_valid;
  p_state_t ps, nps;
  logic [2:0] idx, nidx;
  logic [9:0] sacc, nsacc, hacc, nhacc, nacc;
  logic is_dig, dig_st, ok, perr_n, accept, tmo_hit;
  uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .rx_pin(uart_rx),
    .rx_data(rx_data),
    .rx_data_valid(rx_valid),
    .rx_frame_err(frame_err)
  );
`ifdef DEBUG_UART_RX_TIMEOUT_EN
  localparam int BIT_CYC = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int TMO = 16 * 10 * BIT_CYC;
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt;
  assign tmo_hit = tmo_cnt == TW'(TMO - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_cnt <= '0;
    else tmo_cnt <= (ps == P_HUNT || rx_valid || tmo_hit) ? '0 : tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif
  assign is_dig = rx_data >= CH_0 && rx_data <= CH_9;
  assign dig_st = ps == P_SDIG || ps == P_HDIG;
  assign ok = dig_st ? is_dig : rx_data == exp_char(ps, idx);
  assign nacc = (ps == P_SDIG ? sacc : hacc) * 10'd10 + {6'd0, rx_data[3:0]};
  always_comb begin
    nps = ps;
    nidx = idx;
    nsacc = sacc;
    nhacc = hacc;
    perr_n = 1'b0;
    accept = 1'b0;
    if (frame_err) begin
      nps = P_HUNT;
      nidx = '0;
    end else if (rx_valid) begin
      if (ps == P_HUNT) begin
        if (rx_data == CH_S) begin
          nps = P_HDR1;
          nidx = '0;
          nsacc = '0;
          nhacc = '0;
        end
      end else if (ok) begin
        nsacc = ps == P_SDIG ? nacc : sacc;
        nhacc = ps == P_HDIG ? nacc : hacc;
        nidx = idx == last_idx(ps) ? 3'd0 : idx + 1'b1;
        nps = idx == last_idx(ps) ? next_field(ps) : ps;
        perr_n = ps == P_TAIL && idx == 3'd2 && sacc > 10'd255;
        accept = ps == P_TAIL && idx == 3'd2 && sacc <= 10'd255;
      end else begin
        perr_n = 1'b1;
        nps = rx_data == CH_S ? P_HDR1 : P_HUNT;
        nidx = '0;
        nsacc = '0;
        nhacc = '0;
      end
    end else if (tmo_hit) begin
      perr_n = 1'b1;
      nps = P_HUNT;
      nidx = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps <= P_HUNT;
      idx <= '0;
      sacc <= '0;
      hacc <= '0;
      spo2_value <= 8'd95;
      hr_value <= 10'd75;
      data_valid <= 1'b0;
      parse_err <= 1'b0;
    end else begin
      ps <= nps;
      idx <= nidx;
      sacc <= nsacc;
      hacc <= nhacc;
      data_valid <= accept;
      parse_err <= perr_n;
      if (accept) begin
        spo2_value <= sacc[7:0];
        hr_value <= hacc;
      end
    end
  end
endmodule

// File: tb/tb_debug_uart_rx.sv
// tb_debug_uart_rx: randomized and directed line stimulus checked against a template-matching model
module tb_debug_uart_rx;
  localparam int BIT_CYC = 33;
  localparam string TMPL = "SpO2:###%,HR:### \r\n";
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic [7:0] spo2_value;
  logic [9:0] hr_value;
  logic data_valid, frame_err, parse_err;
  int checks = 0, errors = 0;
  int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int line_buf[19];
  int len = 0, m_spo2 = 95, m_hr = 75;
  debug_uart_rx dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx(uart_rx),
    .spo2_value(spo2_value),
    .hr_value(hr_value),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .parse_err(parse_err)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (parse_err) pe_cnt++;
    if (frame_err) fe_cnt++;
    if (data_valid || parse_err) check("dv_pe_excl", int'(data_valid && parse_err), 0);
  end
  function automatic bit tmpl_ok(int pos, int b);
    int t = int'(TMPL[pos]);
    return t == "#" ? (b >= "0" && b <= "9") : b == t;
  endfunction
  function automatic int field(int p);
    return (line_buf[p] - 48) * 100 + (line_buf[p+1] - 48) * 10 + (line_buf[p+2] - 48);
  endfunction
  task automatic model_byte(int b, bit bad, output int e_dv, output int e_pe, output int e_fe);
    e_dv = 0;
    e_pe = 0;
    e_fe = 0;
    if (bad) begin
      e_fe = 1;
      len = 0;
    end else if (len == 0) begin
      if (b == "S") begin
        line_buf[0] = b;
        len = 1;
      end
    end else if (tmpl_ok(len, b)) begin
      line_buf[len] = b;
      len++;
      if (len == 19) begin
        len = 0;
        if (field(5) > 255) e_pe = 1;
        else begin
          e_dv = 1;
          m_spo2 = field(5);
          m_hr = field(13);
        end
      end
    end else begin
      e_pe = 1;
      line_buf[0] = b;
      len = b == "S" ? 1 : 0;
    end
  endtask
  task automatic clear_counts();
    dv_cnt = 0;
    pe_cnt = 0;
    fe_cnt = 0;
  endtask
  task automatic check_vals(string tag);
    check({tag, "_spo2"}, int'(spo2_value), m_spo2);
    check({tag, "_hr"}, int'(hr_value), m_hr);
  endtask
  task automatic send_byte(logic [7:0] b, bit bad, string tag);
    int e_dv, e_pe, e_fe;
    clear_counts();
    @(posedge clk) uart_rx = 1'b0;
    repeat (BIT_CYC) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_CYC) @(posedge clk);
    end
    uart_rx = !bad;
    repeat (BIT_CYC) @(posedge clk);
    uart_rx = 1'b1;
    repeat ($urandom_range(2, 4)) @(posedge clk);
    @(negedge clk);
    model_byte(int'(b), bad, e_dv, e_pe, e_fe);
    check({tag, "_dv"}, dv_cnt, e_dv);
    check({tag, "_pe"}, pe_cnt, e_pe);
    check({tag, "_fe"}, fe_cnt, e_fe);
    check_vals(tag);
  endtask
  task automatic send_line(string s, int bad_pos, string tag);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], i == bad_pos, $sformatf("%s[%0d]", tag, i));
  endtask
  initial begin
    string s;
    int sv, hv, mode, pos;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_spo2", int'(spo2_value), 95);
    check("rst_hr", int'(hr_value), 75);
    check("rst_dv", int'(data_valid), 0);
    check("rst_pe", int'(parse_err), 0);
    check("rst_fe", int'(frame_err), 0);
    @(posedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_line("SpO2:097%,HX", -1, "bad_hdr");
    check("bad_hdr_hold_spo2", int'(spo2_value), 95);
    check("bad_hdr_hold_hr", int'(hr_value), 75);
    send_line("SpO2:097%,HR:082 \r\n", -1, "good");
    check("good_spo2", int'(spo2_value), 97);
    check("good_hr", int'(hr_value), 82);
    send_line("SpO2:300%,HR:120 \r\n", -1, "spo2_ovf");
    check("ovf_hold_spo2", int'(spo2_value), 97);
    send_line("SpO2:100%,HR:999 \r\n", -1, "max_hr");
    check("max_hr_spo2", int'(spo2_value), 100);
    check("max_hr_hr", int'(hr_value), 999);
    clear_counts();
    @(posedge clk) uart_rx = 1'b0;
    repeat (8) @(posedge clk);
    uart_rx = 1'b1;
    repeat (4 * BIT_CYC) @(posedge clk);
    @(negedge clk);
    check("glitch_dv", dv_cnt, 0);
    check("glitch_pe", pe_cnt, 0);
    check("glitch_fe", fe_cnt, 0);
    check_vals("glitch");
    send_line("SpO2:098%,HR:060 \r\n", -1, "post_glitch");
    send_line("SpO2:091%,HR:070 \r\n", 8, "stop_low");
    check("stop_low_hold_spo2", int'(spo2_value), 98);
    s = "SpO2:055%,HR:044 \r\n";
    for (int i = 0; i < 10; i++) send_byte(s[i], 1'b0, $sformatf("pre_rst[%0d]", i));
    @(posedge clk) rst_n = 1'b0;
    @(posedge clk) rst_n = 1'b1;
    @(negedge clk);
    len = 0;
    m_spo2 = 95;
    m_hr = 75;
    check_vals("mid_rst");
    send_line(s, -1, "post_rst");
    send_line("SpO2:", -1, "stall");
    clear_counts();
    repeat (6000) @(posedge clk);
    @(negedge clk);
`ifdef DEBUG_UART_RX_TIMEOUT_EN
    check("timeout_pe", pe_cnt, 1);
    len = 0;
`else
    check("no_timeout_pe", pe_cnt, 0);
`endif
    check_vals("stall");
    for (int n = 0; n < 2; n++) begin
      sv = $urandom_range(0, 3) == 0 ? $urandom_range(256, 999) : $urandom_range(0, 255);
      hv = $urandom_range(0, 999);
      s = $sformatf("SpO2:%03d%%,HR:%03d \r\n", sv, hv);
      mode = $urandom_range(0, 2);
      pos = $urandom_range(0, 18);
      if (mode == 1) s.putc(pos, byte'($urandom_range(32, 126)));
      send_line(s, mode == 2 ? pos : -1, $sformatf("rnd%0d", n));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
